// File: rtl/chan_dispatch_if.sv
// Producer/consumer bundle for chan_dispatch: one input word handshake plus 32 output slot handshakes.
// CHAN_DISPATCH_BCAST_EN adds the in_bcast request line.
interface chan_dispatch_if #(
  parameter int W = 20,
  parameter int N = 32
);
  localparam int SW = $clog2(N);

  logic                  in_valid;
  logic                  in_ready;
  logic [SW-1:0]         in_sel;
  logic [W-1:0]          in_data;
`ifdef CHAN_DISPATCH_BCAST_EN
  logic                  in_bcast;
`endif
  logic [N-1:0]          out_valid;
  logic [N-1:0]          out_ready;
  logic [N-1:0][W-1:0]   out_data;

`ifdef CHAN_DISPATCH_BCAST_EN
  modport master (
    output in_valid, in_sel, in_data, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_sel, in_data, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
`else
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/chan_dispatch.sv
// Registered 32-channel word dispatcher: each input word lands in the holding slot of its channel.
// Optional broadcast (all slots at once) is enabled by defining CHAN_DISPATCH_BCAST_EN.
module chan_dispatch #(
  parameter int W = 20,
  parameter int N = 32
) (
  input  logic               clk,
  input  logic               rst,
  chan_dispatch_if.slave     bus,
  output logic [5:0]         occupancy,
  output logic [15:0]        accept_cnt
);
  localparam int SW = $clog2(N);

  logic [N-1:0]        full_reg;
  logic [N-1:0]        full_next;
  logic [N-1:0][W-1:0] data_reg;
  logic [N-1:0]        drain;
  logic [N-1:0]        load;
  logic [5:0]          occupancy_reg;
  logic [5:0]          occupancy_next;
  logic [15:0]         accept_cnt_reg;
  logic                bcast;
  logic                ready;
  logic                accept;

`ifdef CHAN_DISPATCH_BCAST_EN
  assign bcast = bus.in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Unicast may reuse a slot being drained this cycle; broadcast waits for every slot to be empty.
  always_comb begin
    ready = 1'b0;
    if (rst) begin
      ready = 1'b0;
    end else if (bcast) begin
      ready = (occupancy_reg == 6'd0);
    end else begin
      ready = ~full_reg[bus.in_sel] | bus.out_ready[bus.in_sel];
    end
  end

  assign accept       = bus.in_valid & ready;
  assign bus.in_ready = ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign drain[gi]     = full_reg[gi] & bus.out_ready[gi];
      assign load[gi]      = accept & (bcast | (bus.in_sel == SW'(gi)));
      assign full_next[gi] = load[gi] | (full_reg[gi] & ~drain[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          full_reg[gi] <= 1'b0;
          data_reg[gi] <= '0;
        end else begin
          full_reg[gi] <= full_next[gi];
          if (load[gi]) begin
            data_reg[gi] <= bus.in_data;
          end
        end
      end
    end
  endgenerate

  // Counting the next full vector keeps occupancy exact under any mix of drains and refills.
  always_comb begin
    occupancy_next = 6'd0;
    for (int i = 0; i < N; i++) begin
      occupancy_next = occupancy_next + 6'(full_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_reg  <= 6'd0;
      accept_cnt_reg <= 16'd0;
    end else begin
      occupancy_reg <= occupancy_next;
      if (accept) begin
        accept_cnt_reg <= accept_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.out_valid = full_reg;
  assign bus.out_data  = data_reg;
  assign occupancy     = occupancy_reg;
  assign accept_cnt    = accept_cnt_reg;
endmodule

// File: tb/tb_chan_dispatch.sv
// Directed self-checking bench for chan_dispatch; broadcast steps run when CHAN_DISPATCH_BCAST_EN is defined.
module tb_chan_dispatch;
  logic        clk;
  logic        rst;
  logic [5:0]  occupancy;
  logic [15:0] accept_cnt;
  int          checks;
  int          failures;

  chan_dispatch_if #(.W(20), .N(32)) bus ();

  chan_dispatch #(.W(20), .N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .occupancy  (occupancy),
    .accept_cnt (accept_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 5'd0;
    bus.in_data   = 20'd0;
    bus.out_ready = 32'd0;
`ifdef CHAN_DISPATCH_BCAST_EN
    bus.in_bcast  = 1'b0;
`endif

    // Reset: in_ready forced low even with a word presented
    tick();
    bus.in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_accept_cnt", 32'(accept_cnt), 32'd0);
    chk("rst_out_data0", 32'(bus.out_data[0]), 32'd0);
    bus.in_sel = 5'd0;  #1; chk("idle_ready_sel0", 32'(bus.in_ready), 32'd1);
    bus.in_sel = 5'd17; #1; chk("idle_ready_sel17", 32'(bus.in_ready), 32'd1);
    bus.in_sel = 5'd31; #1; chk("idle_ready_sel31", 32'(bus.in_ready), 32'd1);

    // Unicast 0x0ABCD to channel 5
    bus.in_valid = 1'b1;
    bus.in_sel   = 5'd5;
    bus.in_data  = 20'h0ABCD;
    #1;
    chk("uni_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("uni_out_valid", bus.out_valid, 32'h0000_0020);
    chk("uni_out_data5", 32'(bus.out_data[5]), 32'h0ABCD);
    chk("uni_occupancy", 32'(occupancy), 32'd1);
    chk("uni_accept_cnt", 32'(accept_cnt), 32'd1);

    // Second word to the full channel is refused
    bus.in_valid = 1'b1;
    bus.in_data  = 20'h11111;
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("full_data_kept", 32'(bus.out_data[5]), 32'h0ABCD);
    chk("full_accept_cnt", 32'(accept_cnt), 32'd1);

    // Same-edge drain and refill of channel 5
    bus.in_data   = 20'h12345;
    bus.out_ready = 32'h0000_0020;
    #1;
    chk("refill_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 32'd0;
    chk("refill_out_data5", 32'(bus.out_data[5]), 32'h12345);
    chk("refill_out_valid", bus.out_valid, 32'h0000_0020);
    chk("refill_occupancy", 32'(occupancy), 32'd1);
    chk("refill_accept_cnt", 32'(accept_cnt), 32'd2);

    // Drain channel 5 while accepting into channel 9
    bus.in_valid  = 1'b1;
    bus.in_sel    = 5'd9;
    bus.in_data   = 20'h00009;
    bus.out_ready = 32'h0000_0020;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 32'd0;
    chk("indep_out_valid", bus.out_valid, 32'h0000_0200);
    chk("indep_occupancy", 32'(occupancy), 32'd1);
    chk("indep_accept_cnt", 32'(accept_cnt), 32'd3);
    bus.out_ready = 32'hFFFF_FFFF;
    tick();
    bus.out_ready = 32'd0;
    chk("drain9_occupancy", 32'(occupancy), 32'd0);
    chk("drain9_out_valid", bus.out_valid, 32'd0);

    // Fill all 32 channels back-to-back
    bus.in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_sel  = 5'(i);
      bus.in_data = 20'(i * 32'h1000 + i);
      #1;
      chk($sformatf("fill_ready_ch%0d", i), 32'(bus.in_ready), 32'd1);
      tick();
    end
    bus.in_sel = 5'd12;
    #1;
    chk("allfull_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    chk("fill_occupancy", 32'(occupancy), 32'd32);
    chk("fill_out_valid", bus.out_valid, 32'hFFFF_FFFF);
    chk("fill_accept_cnt", 32'(accept_cnt), 32'd35);
    chk("fill_out_data0", 32'(bus.out_data[0]), 32'h00000);
    chk("fill_out_data31", 32'(bus.out_data[31]), 32'h1F01F);

    // Partial then full multi-channel drain
    bus.out_ready = 32'h0000_00FF;
    tick();
    chk("part_occupancy", 32'(occupancy), 32'd24);
    chk("part_out_valid", bus.out_valid, 32'hFFFF_FF00);
    bus.out_ready = 32'hFFFF_FFFF;
    tick();
    bus.out_ready = 32'd0;
    chk("drain_all_occupancy", 32'(occupancy), 32'd0);
    chk("drain_all_out_valid", bus.out_valid, 32'd0);
    chk("drain_data_kept31", 32'(bus.out_data[31]), 32'h1F01F);

    // Reset mid-operation with a word presented
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_sel  = 5'(i);
      bus.in_data = 20'hA0000 + 20'(i);
      tick();
    end
    chk("mid_occupancy", 32'(occupancy), 32'd10);
    chk("mid_accept_cnt", 32'(accept_cnt), 32'd45);
    rst         = 1'b1;
    bus.in_sel  = 5'd20;
    bus.in_data = 20'hBEEF0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_accept_cnt", 32'(accept_cnt), 32'd0);
    chk("midrst_out_valid", bus.out_valid, 32'd0);
    chk("midrst_out_data3", 32'(bus.out_data[3]), 32'd0);
    chk("midrst_out_data20", 32'(bus.out_data[20]), 32'd0);

`ifdef CHAN_DISPATCH_BCAST_EN
    // Broadcast blocked by a full slot, even while that slot drains
    bus.in_valid = 1'b1;
    bus.in_sel   = 5'd3;
    bus.in_data  = 20'h33333;
    tick();
    bus.in_bcast  = 1'b1;
    bus.in_sel    = 5'd7;
    bus.in_data   = 20'h00F0F;
    bus.out_ready = 32'h0000_0008;
    #1;
    chk("bcast_blocked_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.out_ready = 32'd0;
    chk("bcast_drained_occ", 32'(occupancy), 32'd0);
    chk("bcast_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    chk("bcast_out_valid", bus.out_valid, 32'hFFFF_FFFF);
    chk("bcast_occupancy", 32'(occupancy), 32'd32);
    chk("bcast_accept_cnt", 32'(accept_cnt), 32'd2);
    chk("bcast_out_data0", 32'(bus.out_data[0]), 32'h00F0F);
    chk("bcast_out_data3", 32'(bus.out_data[3]), 32'h00F0F);
    chk("bcast_out_data31", 32'(bus.out_data[31]), 32'h00F0F);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
